rom_dump_sequencer: RTL and testbench

Autonomous controller that sequences the ROM chip reader through an address range [first_addr..last_addr]. It issues the reader's reset pulse, generates clean increment pulses (assert, hold, release), waits for chip data to settle, and captures each word. Each captured address/data pair goes out on a valid/ready stream toward the UART/host dump path. It replaces manual button stepping in the top level.

---
 rtl/rom_dump_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_rom_dump_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_dump_sequencer.sv
// Autonomous ROM dump sequencer: resets the chip reader, seeks to first_addr, then steps/settles/captures each word onto a valid/ready stream.
// Optional ROM_DUMP_CHECKSUM_EN adds a 16-bit running sum of transferred words on port checksum.
module rom_dump_sequencer #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDRESS_WIDTH  = 9,
  parameter int unsigned STEP_HOLD      = 2,
  parameter int unsigned POST_STEP_WAIT = 3,
  parameter int unsigned SETTLE_CYCLES  = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] first_addr,
  input  logic [ADDRESS_WIDTH-1:0] last_addr,
  output logic                     rdr_reset_n,
  output logic                     rdr_increment,
  output logic                     rdr_decrement,
  input  logic [ADDRESS_WIDTH-1:0] rdr_address,
  input  logic [DATA_WIDTH-1:0]    rdr_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDRESS_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done,
  output logic                     error
`ifdef ROM_DUMP_CHECKSUM_EN
  ,
  output logic [15:0]              checksum
`endif
);

  localparam int unsigned RST_CYCLES = 2;
  localparam int unsigned MAX_AB  = (STEP_HOLD > POST_STEP_WAIT) ? STEP_HOLD : POST_STEP_WAIT;
  localparam int unsigned MAX_ABC = (MAX_AB > SETTLE_CYCLES) ? MAX_AB : SETTLE_CYCLES;
  localparam int unsigned CNT_MAX = (MAX_ABC > RST_CYCLES) ? MAX_ABC : RST_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [3:0] {
    IDLE, RDR_RST, SEEK_CHK, STEP_ON, STEP_OFF, SETTLE, CAPTURE, EMIT, DONE
  } state_t;

  state_t                   state;
  logic [CNT_W-1:0]         cnt;
  logic                     seek;
  logic [ADDRESS_WIDTH-1:0] first_q;
  logic [ADDRESS_WIDTH-1:0] last_q;
  logic [ADDRESS_WIDTH-1:0] exp_addr;

  // The reader only ever counts upward.
  assign rdr_decrement = 1'b0;

  // Sequencer: each timed state loads cnt with (cycles-1) on entry and leaves when it reaches zero.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      seek          <= 1'b0;
      first_q       <= '0;
      last_q        <= '0;
      exp_addr      <= '0;
      rdr_reset_n   <= 1'b1;
      rdr_increment <= 1'b0;
      out_valid     <= 1'b0;
      out_addr      <= '0;
      out_data      <= '0;
      out_last      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
`ifdef ROM_DUMP_CHECKSUM_EN
      checksum      <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            first_q  <= first_addr;
            last_q   <= last_addr;
            exp_addr <= '0;
            busy     <= 1'b1;
`ifdef ROM_DUMP_CHECKSUM_EN
            checksum <= '0;
`endif
            if (first_addr > last_addr) begin
              error <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              error       <= 1'b0;
              rdr_reset_n <= 1'b0;
              cnt         <= CNT_W'(RST_CYCLES - 1);
              state       <= RDR_RST;
            end
          end
        end

        RDR_RST: begin
          if (cnt == '0) begin
            rdr_reset_n <= 1'b1;
            state       <= SEEK_CHK;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        // Stop seeking once either side reaches first_addr; a disagreement is caught at CAPTURE.
        SEEK_CHK: begin
          if (rdr_address == first_q || exp_addr == first_q) begin
            seek  <= 1'b0;
            cnt   <= CNT_W'(SETTLE_CYCLES - 1);
            state <= SETTLE;
          end else begin
            seek          <= 1'b1;
            rdr_increment <= 1'b1;
            cnt           <= CNT_W'(STEP_HOLD - 1);
            state         <= STEP_ON;
          end
        end

        STEP_ON: begin
          if (cnt == '0) begin
            rdr_increment <= 1'b0;
            exp_addr      <= exp_addr + ADDRESS_WIDTH'(1);
            cnt           <= CNT_W'(POST_STEP_WAIT - 1);
            state         <= STEP_OFF;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        STEP_OFF: begin
          if (cnt == '0) begin
            if (seek) begin
              state <= SEEK_CHK;
            end else begin
              cnt   <= CNT_W'(SETTLE_CYCLES - 1);
              state <= SETTLE;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        SETTLE: begin
          if (cnt == '0) begin
            state <= CAPTURE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        CAPTURE: begin
          if (rdr_address != exp_addr) begin
            error <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            out_addr  <= exp_addr;
            out_data  <= rdr_data;
            out_last  <= (exp_addr == last_q);
            out_valid <= 1'b1;
            state     <= EMIT;
          end
        end

        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
`ifdef ROM_DUMP_CHECKSUM_EN
            checksum  <= checksum + 16'(out_data);
`endif
            if (out_last) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              rdr_increment <= 1'b1;
              cnt           <= CNT_W'(STEP_HOLD - 1);
              state         <= STEP_ON;
            end
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_dump_sequencer.sv
// Self-checking bench for rom_dump_sequencer: behavioural reader model, word-queue scoreboard, directed dump scenarios.
`timescale 1ns/1ps
module tb_rom_dump_sequencer;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 9;
  localparam int unsigned SH = 2;
  localparam int unsigned PW = 3;
  localparam int unsigned SC = 4;
  localparam int PERIOD = int'(SH + PW + SC + 2);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] first_addr = '0;
  logic [AW-1:0] last_addr = '0;
  logic          rdr_reset_n, rdr_increment, rdr_decrement;
  logic [AW-1:0] rdr_address;
  logic [DW-1:0] rdr_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic          out_last, busy, done, error;
`ifdef ROM_DUMP_CHECKSUM_EN
  logic [15:0]   checksum;
`endif

  always #5 clk = ~clk;

  rom_dump_sequencer #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .STEP_HOLD(SH),
    .POST_STEP_WAIT(PW), .SETTLE_CYCLES(SC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .first_addr(first_addr), .last_addr(last_addr),
    .rdr_reset_n(rdr_reset_n), .rdr_increment(rdr_increment),
    .rdr_decrement(rdr_decrement), .rdr_address(rdr_address), .rdr_data(rdr_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .out_last(out_last), .busy(busy), .done(done), .error(error)
`ifdef ROM_DUMP_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  function automatic logic [DW-1:0] rom_val(input logic [AW-1:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  // Reader model: counts on rising edges of increment, resets to 0, registers data one cycle behind the address.
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data = '0;
  logic          inc_q = 1'b0;
  logic          skip_en = 1'b0;
  logic          skip_done = 1'b0;
  assign rdr_address = rd_addr;
  assign rdr_data    = rd_data;

  always @(posedge clk) begin
    inc_q   <= rdr_increment;
    rd_data <= rom_val(rd_addr);
    if (!rdr_reset_n) begin
      rd_addr   <= '0;
      skip_done <= 1'b0;
    end else if (rdr_increment && !inc_q) begin
      if (skip_en && !skip_done && rd_addr == AW'(1)) skip_done <= 1'b1;
      else rd_addr <= rd_addr + AW'(1);
    end
  end

  int n_test = 0;
  int n_fail = 0;

  task automatic chk(input bit ok, input string name, input int act, input int expv);
    n_test++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t", name, act, act, expv, expv, $time);
    end
  endtask

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          l;
  } word_t;
  word_t exp_q[$];

  int            cyc = 0, done_cnt = 0, inc_cnt = 0, valid_cnt = 0, xfer_cnt = 0;
  logic [AW-1:0] log_a[0:63];
  logic [DW-1:0] log_d[0:63];
  logic          log_l[0:63];
  int            log_cyc[0:63];
  logic          hold_q = 1'b0;
  word_t         held;

  // Per-cycle compare: stream scoreboard, hold stability and reader-interface invariants.
  always @(negedge clk) begin
    word_t w;
    cyc++;
    if (!reset_n) begin
      hold_q = 1'b0;
    end else begin
      chk(rdr_decrement == 1'b0, "decrement_low", int'(rdr_decrement), 0);
      chk(!(rdr_increment && !rdr_reset_n), "inc_during_rdr_reset", int'(rdr_increment), 0);
      if (rdr_increment) inc_cnt++;
      if (out_valid) valid_cnt++;
      if (done) done_cnt++;
      if (hold_q) begin
        chk(out_valid == 1'b1, "hold_valid", int'(out_valid), 1);
        chk(out_addr == held.a, "hold_addr", int'(out_addr), int'(held.a));
        chk(out_data == held.d, "hold_data", int'(out_data), int'(held.d));
        chk(out_last == held.l, "hold_last", int'(out_last), int'(held.l));
      end
      if (out_valid && out_ready) begin
        chk(busy == 1'b1, "busy_on_xfer", int'(busy), 1);
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_xfer", int'(out_addr), -1);
        end else begin
          w = exp_q.pop_front();
          chk(out_addr == w.a, "xfer_addr", int'(out_addr), int'(w.a));
          chk(out_data == w.d, "xfer_data", int'(out_data), int'(w.d));
          chk(out_last == w.l, "xfer_last", int'(out_last), int'(w.l));
        end
        if (xfer_cnt < 64) begin
          log_a[xfer_cnt] = out_addr;
          log_d[xfer_cnt] = out_data;
          log_l[xfer_cnt] = out_last;
          log_cyc[xfer_cnt] = cyc;
        end
        xfer_cnt++;
      end
      hold_q = out_valid && !out_ready;
      held   = '{out_addr, out_data, out_last};
    end
  end

  task automatic expect_range(input int f, input int l, input int stop);
    for (int a = f; a <= stop; a++) exp_q.push_back('{AW'(a), rom_val(AW'(a)), (a == l)});
  endtask

  task automatic start_dump(input int f, input int l);
    @(posedge clk); #1;
    first_addr = AW'(f);
    last_addr  = AW'(l);
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int lat);
    lat = -1;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        lat = i;
        break;
      end
      @(posedge clk); #1;
    end
    chk(lat >= 0, "done_timeout", lat, 0);
    @(posedge clk); #1;
    chk(busy == 1'b0, "busy_after_done", int'(busy), 0);
  endtask

  task automatic wait_valid(input int budget);
    int seen = 0;
    for (int i = 0; i < budget; i++) begin
      if (out_valid) begin
        seen = 1;
        break;
      end
      @(posedge clk); #1;
    end
    chk(seen == 1, "valid_timeout", seen, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, x0, d0, i0, v0;
    int sum;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk(out_valid == 1'b0, "rst_out_valid", int'(out_valid), 0);
    chk(busy == 1'b0, "rst_busy", int'(busy), 0);
    chk(done == 1'b0, "rst_done", int'(done), 0);
    chk(error == 1'b0, "rst_error", int'(error), 0);
    chk(rdr_reset_n == 1'b1, "rst_rdr_reset_n", int'(rdr_reset_n), 1);
    chk(rdr_increment == 1'b0, "rst_rdr_increment", int'(rdr_increment), 0);
    chk(out_addr == '0, "rst_out_addr", int'(out_addr), 0);
    chk(out_data == '0, "rst_out_data", int'(out_data), 0);
    chk(out_last == 1'b0, "rst_out_last", int'(out_last), 0);
`ifdef ROM_DUMP_CHECKSUM_EN
    chk(checksum == 16'h0, "rst_checksum", int'(checksum), 0);
`endif
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Range 0..3 with ready held high
    x0 = xfer_cnt; d0 = done_cnt;
    expect_range(0, 3, 3);
    start_dump(0, 3);
    wait_done(400, lat);
    chk(xfer_cnt - x0 == 4, "r03_count", xfer_cnt - x0, 4);
    chk(exp_q.size() == 0, "r03_queue_empty", exp_q.size(), 0);
    chk(error == 1'b0, "r03_error", int'(error), 0);
    chk(done_cnt - d0 == 1, "r03_done_pulses", done_cnt - d0, 1);
    chk(log_cyc[x0+1] - log_cyc[x0] == PERIOD, "r03_step_period", log_cyc[x0+1] - log_cyc[x0], PERIOD);
    chk(log_cyc[x0+3] - log_cyc[x0+2] == PERIOD, "r03_step_period2", log_cyc[x0+3] - log_cyc[x0+2], PERIOD);
    chk(log_d[x0] == 8'hA5, "r03_word0_lit", int'(log_d[x0]), 'hA5);
    chk(log_d[x0+1] == 8'hA4, "r03_word1_lit", int'(log_d[x0+1]), 'hA4);
    chk(log_d[x0+3] == 8'hA6, "r03_word3_lit", int'(log_d[x0+3]), 'hA6);
    chk(log_l[x0+2] == 1'b0, "r03_word2_not_last", int'(log_l[x0+2]), 0);
    chk(log_l[x0+3] == 1'b1, "r03_word3_last", int'(log_l[x0+3]), 1);
`ifdef ROM_DUMP_CHECKSUM_EN
    sum = 0;
    for (int a = 0; a <= 3; a++) sum += int'(rom_val(AW'(a)));
    chk(checksum == 16'(sum), "r03_checksum", int'(checksum), sum % 65536);
`endif

    // Reversed range aborts immediately
    repeat (2) @(posedge clk);
    d0 = done_cnt; i0 = inc_cnt; v0 = valid_cnt;
    start_dump(7, 2);
    chk(error == 1'b1, "rev_error", int'(error), 1);
    wait_done(10, lat);
    chk(lat >= 0 && lat < 2, "rev_done_latency", lat, 0);
    chk(done_cnt - d0 == 1, "rev_done_pulses", done_cnt - d0, 1);
    chk(inc_cnt - i0 == 0, "rev_no_increment", inc_cnt - i0, 0);
    chk(valid_cnt - v0 == 0, "rev_no_valid", valid_cnt - v0, 0);

    // Seek to 509, dump 509..511; the new start must clear the sticky error
    repeat (2) @(posedge clk);
    x0 = xfer_cnt; d0 = done_cnt;
    expect_range(509, 511, 511);
    start_dump(509, 511);
    chk(error == 1'b0, "seek_error_cleared", int'(error), 0);
    wait_done(6000, lat);
    chk(xfer_cnt - x0 == 3, "seek_count", xfer_cnt - x0, 3);
    chk(exp_q.size() == 0, "seek_queue_empty", exp_q.size(), 0);
    chk(log_a[x0] == AW'(509), "seek_first_addr", int'(log_a[x0]), 509);
    chk(log_d[x0] == 8'h58, "seek_first_data_lit", int'(log_d[x0]), 'h58);
    chk(log_l[x0+2] == 1'b1, "seek_last_flag", int'(log_l[x0+2]), 1);
    chk(error == 1'b0, "seek_error", int'(error), 0);
    chk(done_cnt - d0 == 1, "seek_done_pulses", done_cnt - d0, 1);

    // Single word with backpressure
    repeat (2) @(posedge clk);
    x0 = xfer_cnt;
    out_ready = 1'b0;
    expect_range(5, 5, 5);
    start_dump(5, 5);
    wait_valid(200);
    repeat (10) @(posedge clk);
    #1;
    chk(xfer_cnt - x0 == 0, "bp_no_early_xfer", xfer_cnt - x0, 0);
    out_ready = 1'b1;
    wait_done(50, lat);
    chk(xfer_cnt - x0 == 1, "bp_count", xfer_cnt - x0, 1);
    chk(log_a[x0] == AW'(5), "bp_addr_lit", int'(log_a[x0]), 5);
    chk(log_d[x0] == 8'hA0, "bp_data_lit", int'(log_d[x0]), 'hA0);
    chk(log_l[x0] == 1'b1, "bp_last", int'(log_l[x0]), 1);
    chk(error == 1'b0, "bp_error", int'(error), 0);

    // Reader drops the step to address 2
    repeat (2) @(posedge clk);
    x0 = xfer_cnt; d0 = done_cnt;
    skip_en = 1'b1;
    expect_range(0, 4, 1);
    start_dump(0, 4);
    wait_done(400, lat);
    chk(xfer_cnt - x0 == 2, "skip_count", xfer_cnt - x0, 2);
    chk(exp_q.size() == 0, "skip_queue_empty", exp_q.size(), 0);
    chk(error == 1'b1, "skip_error", int'(error), 1);
    chk(done_cnt - d0 == 1, "skip_done_pulses", done_cnt - d0, 1);
    skip_en = 1'b0;

    // Reset while a word is waiting in EMIT
    repeat (2) @(posedge clk);
    x0 = xfer_cnt; d0 = done_cnt;
    out_ready = 1'b0;
    start_dump(0, 3);
    wait_valid(200);
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk(out_valid == 1'b0, "mid_rst_valid", int'(out_valid), 0);
    chk(busy == 1'b0, "mid_rst_busy", int'(busy), 0);
    chk(rdr_increment == 1'b0, "mid_rst_increment", int'(rdr_increment), 0);
    chk(rdr_reset_n == 1'b1, "mid_rst_rdr_reset_n", int'(rdr_reset_n), 1);
    reset_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk(done_cnt - d0 == 0, "mid_rst_no_done", done_cnt - d0, 0);
    chk(xfer_cnt - x0 == 0, "mid_rst_no_xfer", xfer_cnt - x0, 0);
    chk(busy == 1'b0, "mid_rst_idle", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
    $finish;
  end
endmodule
